// File: rtl/uart_stdio_bridge.sv
// uart_stdio_bridge: 8N1 host UART <-> emulator character I/O handshake bridge.
module uart_stdio_bridge #(
    parameter int unsigned CLKS_PER_BIT  = 434,
    parameter int unsigned RX_FIFO_DEPTH = 4
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       uart_rx,
    output logic       uart_tx,
    input  logic       Cout,
    input  logic [7:0] stdout,
    input  logic       CinReq,
    output logic [7:0] stdin,
    output logic       CioAcq,
    output logic       rx_overrun,
    output logic       rx_frame_err
);

    localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_M1  = CLKS_PER_BIT - 1;
    localparam int unsigned HALF_M1 = (CLKS_PER_BIT / 2) - 1;
    localparam int unsigned AW      = $clog2(RX_FIFO_DEPTH);
    localparam int unsigned PW      = AW + 1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // Synchroniser and previous-sample flop for start-edge detection
    logic r_rx_meta, r_rx_sync, r_rx_last;

    rx_state_t        r_rx_state, w_rx_state_n;
    logic [CNT_W-1:0] r_rx_cnt,   w_rx_cnt_n;
    logic [2:0]       r_rx_bit,   w_rx_bit_n;
    logic [7:0]       r_rx_shift, w_rx_shift_n;
    logic             r_rx_wait,  w_rx_wait_n;
    logic             w_rx_done,  w_rx_ferr;

    tx_state_t        r_tx_state, w_tx_state_n;
    logic [CNT_W-1:0] r_tx_cnt,   w_tx_cnt_n;
    logic [2:0]       r_tx_bit,   w_tx_bit_n;
    logic [7:0]       r_tx_shift, w_tx_shift_n;
    logic             r_tx,       w_tx_n;

    logic [7:0]       r_fifo_mem [RX_FIFO_DEPTH];
    logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
    logic             w_fifo_empty, w_fifo_full, w_push, w_ovr_set;

    logic             r_out_armed, r_in_armed, r_ack, r_overrun, r_ferr;
    logic [7:0]       r_stdin;
    logic             w_out_grant, w_in_grant;

    assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
    assign w_fifo_full  = (r_wr_ptr == {~r_rd_ptr[AW], r_rd_ptr[AW-1:0]});
    assign w_push       = w_rx_done & ~w_fifo_full;
    assign w_ovr_set    = w_rx_done & w_fifo_full;

    // Output wins ties; no grant right after an acknowledge keeps CioAcq single-cycle
    assign w_out_grant = Cout & r_out_armed & (r_tx_state == TX_IDLE) & ~r_ack;
    assign w_in_grant  = CinReq & r_in_armed & ~w_fifo_empty & ~w_out_grant & ~r_ack;

    // RX next-state: mid-bit sampling, glitch reject, stop-bit check
    always_comb begin
        w_rx_state_n = r_rx_state;
        w_rx_cnt_n   = r_rx_cnt + CNT_W'(1);
        w_rx_bit_n   = r_rx_bit;
        w_rx_shift_n = r_rx_shift;
        w_rx_wait_n  = r_rx_wait;
        w_rx_done    = 1'b0;
        w_rx_ferr    = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_n = '0;
                if (r_rx_last && !r_rx_sync) w_rx_state_n = RX_START;
            end
            RX_START: begin
                if (r_rx_cnt == CNT_W'(HALF_M1)) begin
                    w_rx_cnt_n = '0;
                    w_rx_bit_n = 3'd0;
                    w_rx_state_n = r_rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == CNT_W'(BIT_M1)) begin
                    w_rx_cnt_n   = '0;
                    w_rx_shift_n = {r_rx_sync, r_rx_shift[7:1]};
                    if (r_rx_bit == 3'd7) w_rx_state_n = RX_STOP;
                    else                  w_rx_bit_n   = r_rx_bit + 3'd1;
                end
            end
            RX_STOP: begin
                if (r_rx_wait) begin
                    w_rx_cnt_n = '0;
                    if (r_rx_sync) begin
                        w_rx_wait_n  = 1'b0;
                        w_rx_state_n = RX_IDLE;
                    end
                end else if (r_rx_cnt == CNT_W'(BIT_M1)) begin
                    w_rx_cnt_n = '0;
                    if (r_rx_sync) begin
                        w_rx_done    = 1'b1;
                        w_rx_state_n = RX_IDLE;
                    end else begin
                        w_rx_ferr   = 1'b1;
                        w_rx_wait_n = 1'b1;
                    end
                end
            end
            default: w_rx_state_n = RX_IDLE;
        endcase
    end

    // TX next-state: start, 8 data bits LSB first, stop; each CLKS_PER_BIT wide
    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_cnt_n   = r_tx_cnt + CNT_W'(1);
        w_tx_bit_n   = r_tx_bit;
        w_tx_shift_n = r_tx_shift;
        w_tx_n       = r_tx;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_cnt_n = '0;
                w_tx_n     = 1'b1;
                if (w_out_grant) begin
                    w_tx_state_n = TX_START;
                    w_tx_shift_n = stdout;
                    w_tx_bit_n   = 3'd0;
                    w_tx_n       = 1'b0;
                end
            end
            TX_START: begin
                if (r_tx_cnt == CNT_W'(BIT_M1)) begin
                    w_tx_cnt_n   = '0;
                    w_tx_state_n = TX_DATA;
                    w_tx_n       = r_tx_shift[0];
                end
            end
            TX_DATA: begin
                if (r_tx_cnt == CNT_W'(BIT_M1)) begin
                    w_tx_cnt_n = '0;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_n = TX_STOP;
                        w_tx_n       = 1'b1;
                    end else begin
                        w_tx_bit_n   = r_tx_bit + 3'd1;
                        w_tx_shift_n = {1'b0, r_tx_shift[7:1]};
                        w_tx_n       = r_tx_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (r_tx_cnt == CNT_W'(BIT_M1)) begin
                    w_tx_cnt_n   = '0;
                    w_tx_state_n = TX_IDLE;
                end
            end
            default: w_tx_state_n = TX_IDLE;
        endcase
    end

    // State, datapath and handshake registers
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_rx_meta   <= 1'b1;
            r_rx_sync   <= 1'b1;
            r_rx_last   <= 1'b1;
            r_rx_state  <= RX_IDLE;
            r_rx_cnt    <= '0;
            r_rx_bit    <= 3'd0;
            r_rx_shift  <= 8'h00;
            r_rx_wait   <= 1'b0;
            r_tx_state  <= TX_IDLE;
            r_tx_cnt    <= '0;
            r_tx_bit    <= 3'd0;
            r_tx_shift  <= 8'h00;
            r_tx        <= 1'b1;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_out_armed <= 1'b1;
            r_in_armed  <= 1'b1;
            r_ack       <= 1'b0;
            r_stdin     <= 8'h00;
            r_overrun   <= 1'b0;
            r_ferr      <= 1'b0;
        end else begin
            r_rx_meta   <= uart_rx;
            r_rx_sync   <= r_rx_meta;
            r_rx_last   <= r_rx_sync;
            r_rx_state  <= w_rx_state_n;
            r_rx_cnt    <= w_rx_cnt_n;
            r_rx_bit    <= w_rx_bit_n;
            r_rx_shift  <= w_rx_shift_n;
            r_rx_wait   <= w_rx_wait_n;
            r_tx_state  <= w_tx_state_n;
            r_tx_cnt    <= w_tx_cnt_n;
            r_tx_bit    <= w_tx_bit_n;
            r_tx_shift  <= w_tx_shift_n;
            r_tx        <= w_tx_n;
            if (w_push)     r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_in_grant) r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_out_grant) r_out_armed <= 1'b0;
            else if (!Cout)  r_out_armed <= 1'b1;
            if (w_in_grant)   r_in_armed <= 1'b0;
            else if (!CinReq) r_in_armed <= 1'b1;
            r_ack <= w_out_grant | w_in_grant;
            if (w_in_grant) r_stdin <= r_fifo_mem[r_rd_ptr[AW-1:0]];
            if (w_ovr_set)  r_overrun <= 1'b1;
            r_ferr <= w_rx_ferr;
        end
    end

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge Clk) begin
        if (w_push) r_fifo_mem[r_wr_ptr[AW-1:0]] <= r_rx_shift;
    end

    assign uart_tx      = r_tx;
    assign stdin        = r_stdin;
    assign CioAcq       = r_ack;
    assign rx_overrun   = r_overrun;
    assign rx_frame_err = r_ferr;

endmodule

// File: tb/tb_uart_stdio_bridge.sv
// Directed bench for uart_stdio_bridge with CLKS_PER_BIT=4, RX_FIFO_DEPTH=4.
module tb_uart_stdio_bridge;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       uart_rx;
    logic       uart_tx;
    logic       Cout;
    logic [7:0] stdout;
    logic       CinReq;
    logic [7:0] stdin;
    logic       CioAcq;
    logic       rx_overrun;
    logic       rx_frame_err;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int ferr_cnt = 0;
    int b2b_cnt  = 0;
    logic prev_ack = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] wire_bits;   // index i = i-th bit on the line
    } vec_t;
    vec_t vecs[5];

    uart_stdio_bridge #(.CLKS_PER_BIT(4), .RX_FIFO_DEPTH(4)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .Cout(Cout), .stdout(stdout), .CinReq(CinReq), .stdin(stdin),
        .CioAcq(CioAcq), .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Event monitors sampled on the falling edge
    always @(negedge Clk) begin
        if (rx_frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
        if (Rst_n === 1'b1 && CioAcq === 1'b1 && prev_ack === 1'b1) b2b_cnt <= b2b_cnt + 1;
        prev_ack <= (CioAcq === 1'b1);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic send_frame(input logic [9:0] bits);
        for (int i = 0; i < 10; i++) begin
            uart_rx = bits[i];
            repeat (4) tick();
        end
        uart_rx = 1'b1;
        repeat (6) tick();
    endtask

    initial begin
        logic [39:0] got, exp40;
        int extra, t1, t2, fe0;
        logic found;

        vecs[0] = '{8'h41, 10'b1_01000001_0};
        vecs[1] = '{8'h35, 10'b1_00110101_0};
        vecs[2] = '{8'h00, 10'b1_00000000_0};
        vecs[3] = '{8'hFF, 10'b1_11111111_0};
        vecs[4] = '{8'hA5, 10'b1_10100101_0};

        Rst_n = 1'b0; uart_rx = 1'b1; Cout = 1'b0; stdout = 8'h00; CinReq = 1'b0;

        // Reset held with a toggling line
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            uart_rx = ~uart_rx;
            tick();
            if (uart_tx !== 1'b1 || CioAcq !== 1'b0 || stdin !== 8'h00) extra++;
        end
        chk("reset_hold", 64'(extra), 64'd0);
        chk("reset_ovr", 64'(rx_overrun), 64'd0);
        chk("reset_ferr", 64'(rx_frame_err), 64'd0);
        uart_rx = 1'b1;
        Rst_n = 1'b1;
        repeat (5) tick();

        // TX frames from the table
        for (int v = 0; v < 5; v++) begin
            Cout = 1'b1; stdout = vecs[v].data;
            tick();
            chk("tx_ack", 64'(CioAcq), 64'd1);
            Cout = 1'b0; stdout = ~vecs[v].data;
            extra = 0;
            for (int j = 0; j < 40; j++) begin
                got[j]   = uart_tx;
                exp40[j] = vecs[v].wire_bits[j / 4];
                if (j > 0 && CioAcq === 1'b1) extra++;
                tick();
            end
            chk("tx_frame", 64'(got), 64'(exp40));
            chk("tx_single_ack", 64'(extra), 64'd0);
        end

        // Re-raised Cout waits for TX idle; held Cout is not acknowledged again
        Cout = 1'b1; stdout = 8'h41;
        tick();
        t1 = cyc;
        chk("tx2_first_ack", 64'(CioAcq), 64'd1);
        Cout = 1'b0;
        tick();
        Cout = 1'b1;
        found = 1'b0; t2 = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            tick();
            if (CioAcq === 1'b1) begin found = 1'b1; t2 = cyc; end
        end
        chk("tx2_second_ack_seen", 64'(found), 64'd1);
        chk("tx2_ack_spacing", 64'(t2 - t1), 64'd41);
        extra = 0;
        for (int k = 0; k < 45; k++) begin
            tick();
            if (CioAcq === 1'b1) extra++;
        end
        chk("tx2_held_no_ack", 64'(extra), 64'd0);
        chk("tx2_idle_high", 64'(uart_tx), 64'd1);
        Cout = 1'b0;
        tick();

        // RX frames from the table
        for (int v = 0; v < 5; v++) begin
            send_frame(vecs[v].wire_bits);
            CinReq = 1'b1;
            tick();
            chk("rx_ack", 64'(CioAcq), 64'd1);
            chk("rx_stdin", 64'(stdin), 64'(vecs[v].data));
            extra = 0;
            for (int k = 0; k < 6; k++) begin
                tick();
                if (CioAcq === 1'b1) extra++;
            end
            chk("rx_held_empty", 64'(extra), 64'd0);
            CinReq = 1'b0;
            tick();
        end

        // One-cycle glitch pushes nothing
        fe0 = ferr_cnt;
        uart_rx = 1'b0;
        tick();
        uart_rx = 1'b1;
        repeat (20) tick();
        CinReq = 1'b1;
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (CioAcq === 1'b1) extra++;
        end
        chk("glitch_no_byte", 64'(extra), 64'd0);
        chk("glitch_no_ferr", 64'(ferr_cnt - fe0), 64'd0);
        CinReq = 1'b0;
        tick();

        // Frame error leaves the queued byte alone
        send_frame(10'b1_01100001_0);
        fe0 = ferr_cnt;
        send_frame(10'b0_00001111_0);
        repeat (4) tick();
        chk("ferr_pulse_once", 64'(ferr_cnt - fe0), 64'd1);
        CinReq = 1'b1;
        tick();
        chk("ferr_ack", 64'(CioAcq), 64'd1);
        chk("ferr_stdin", 64'(stdin), 64'h61);
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (CioAcq === 1'b1) extra++;
        end
        chk("ferr_fifo_unchanged", 64'(extra), 64'd0);
        CinReq = 1'b0;
        tick();

        // Overrun: five bytes into a four-entry FIFO
        for (int b = 0; b < 5; b++) begin
            logic [7:0] d;
            d = 8'h30 + 8'(b);
            send_frame({1'b1, d, 1'b0});
            if (b == 3) chk("ovr_not_yet", 64'(rx_overrun), 64'd0);
        end
        chk("ovr_set", 64'(rx_overrun), 64'd1);
        for (int b = 0; b < 4; b++) begin
            CinReq = 1'b1;
            tick();
            chk("ovr_pop_ack", 64'(CioAcq), 64'd1);
            chk("ovr_pop_data", 64'(stdin), 64'h30 + 64'(b));
            CinReq = 1'b0;
            tick();
        end
        CinReq = 1'b1;
        extra = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (CioAcq === 1'b1) extra++;
        end
        chk("ovr_fifo_drained", 64'(extra), 64'd0);
        chk("ovr_sticky", 64'(rx_overrun), 64'd1);
        CinReq = 1'b0;
        tick();

        // Simultaneous requests: output first, input on a later cycle
        send_frame({1'b1, 8'h7A, 1'b0});
        Cout = 1'b1; stdout = 8'h55; CinReq = 1'b1;
        tick();
        t1 = cyc;
        chk("sim_out_ack", 64'(CioAcq), 64'd1);
        chk("sim_out_first", 64'(uart_tx), 64'd0);
        chk("sim_stdin_unchanged", 64'(stdin), 64'h33);
        Cout = 1'b0;
        found = 1'b0; t2 = 0;
        for (int k = 0; k < 8 && !found; k++) begin
            tick();
            if (CioAcq === 1'b1) begin found = 1'b1; t2 = cyc; end
        end
        chk("sim_in_ack_seen", 64'(found), 64'd1);
        chk("sim_in_later", 64'(t2 - t1 >= 2), 64'd1);
        chk("sim_in_data", 64'(stdin), 64'h7A);
        CinReq = 1'b0;
        repeat (45) tick();

        // Reset mid-frame abandons TX and clears sticky overrun
        Cout = 1'b1; stdout = 8'h00;
        tick();
        Cout = 1'b0;
        repeat (6) tick();
        chk("mid_tx_low", 64'(uart_tx), 64'd0);
        Rst_n = 1'b0;
        tick();
        chk("mid_rst_tx_high", 64'(uart_tx), 64'd1);
        chk("mid_rst_ovr_clear", 64'(rx_overrun), 64'd0);
        Rst_n = 1'b1;
        extra = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (uart_tx !== 1'b1) extra++;
        end
        chk("mid_rst_abandoned", 64'(extra), 64'd0);

        chk("no_b2b_ack", 64'(b2b_cnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_stdio_bridge.md
# uart_stdio_bridge

Serial console stage that sits between a host UART and the emulator's character I/O. It deserialises host bytes into the `stdin` / `CinReq` / `CioAcq` input handshake. It also serialises bytes presented on `stdout` with `Cout` back to the host. It replaces the MS6205/keyboard console path when the machine is driven from a PC terminal. All I/O is 8N1, LSB first.

## Interface
- `CLKS_PER_BIT`, default 434: clocks per UART bit (50 MHz / 115200). Legal range is 4 to 65535.
- `RX_FIFO_DEPTH`, default 4: receive FIFO entries. Must be a power of 2, at least 2.
- `Clk` input, 1 bit: the only clock. Everything is rising-edge.
- `Rst_n` input, 1 bit: reset. Synchronous and active-low.
- `uart_rx` input, 1 bit: serial input from the host. Asynchronous; idles high.
- `uart_tx` output, 1 bit: serial output to the host. Idles high.
- `Cout` input, 1 bit: the core requests output. Level; held until acknowledged.
- `stdout` input, 8 bits: ASCII byte to send. Valid while `Cout` is high.
- `CinReq` input, 1 bit: the core requests input. Level; held until acknowledged.
- `stdin` output, 8 bits: ASCII byte delivered to the core.
- `CioAcq` output, 1 bit: single-cycle acknowledge for either request.
- `rx_overrun` output, 1 bit: sticky. A received byte was dropped because the FIFO was full.
- `rx_frame_err` output, 1 bit: one-cycle pulse. A received stop bit was sampled low.

## Operation
**Reset values.** `uart_tx`=1, `stdin`=0, `CioAcq`=0, `rx_overrun`=0, `rx_frame_err`=0. The FIFO is empty, both FSMs are idle, and both request flags are armed.

**Reset mid-operation.** Any frame in progress is abandoned. `uart_tx` is high on the cycle after `Rst_n` is sampled low.

**RX path**
- `uart_rx` passes through a 2-flop synchroniser.
- RX FSM states: IDLE, START, DATA, STOP.
- IDLE → START when the synchronised line goes from 1 to 0.
- START checks the line at `CLKS_PER_BIT/2` (integer divide). If it reads 1, the start was a glitch: return to IDLE, nothing recorded.
- DATA samples 8 bits, one every `CLKS_PER_BIT` after the mid-start sample, LSB first.
- STOP samples one more bit at the same spacing:
  - Stop bit = 1 and FIFO not full: push the byte.
  - Stop bit = 1 and FIFO full: drop the byte and set `rx_overrun`. It clears only on reset.
  - Stop bit = 0: drop the byte and pulse `rx_frame_err`. The FSM waits in STOP until the line is 1, then goes to IDLE.

**TX path**
- TX FSM states: IDLE, START, DATA, STOP. Each state lasts exactly `CLKS_PER_BIT` cycles per bit.
- A frame is 1 start bit, 8 data bits, then 1 stop bit: 10·`CLKS_PER_BIT` cycles in total.
- The byte is taken from a shift register latched at acknowledge. `stdout` may change after `CioAcq`.

**Handshake arbitration**
- Each request has an armed flag. It is cleared when that request is acknowledged and re-set on the first cycle the request is sampled low. No request is acknowledged twice without dropping in between.
- Output grant: `Cout` is high, armed, and the TX FSM is IDLE. Latch `stdout`, start TX, pulse `CioAcq`.
- Input grant: `CinReq` is high, armed, and the FIFO is not empty. Drive `stdin` with the FIFO head, pop it, pulse `CioAcq`.
- If both are grantable in the same cycle, output wins. Input is granted no earlier than the following cycle.
- `CioAcq` is never high on two consecutive cycles.
- `stdin` holds its last delivered value until the next input grant.
- A push and a pop in the same cycle are both performed. Occupancy is unchanged, and the pop uses the pre-push head.

## Timing
- **Output.** `Cout` is sampled high at edge N with TX idle. `CioAcq`=1 during cycle N+1, and `uart_tx` drives the start bit from cycle N+1.
- **TX idle again.** The TX FSM is idle after edge N+10·`CLKS_PER_BIT`. A held, re-armed `Cout` can be acknowledged at the earliest on the cycle after that.
- **Input.** `CinReq` is sampled high and armed with data present at edge N. `CioAcq`=1 and `stdin` is valid in cycle N+1.
- **RX availability.** A received byte is poppable on the cycle after the stop-bit sample. Relative to the start edge on the pins, the stop-bit sample occurs at 2 (synchroniser) + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` cycles.
- **Waiting request.** If `CinReq` is waiting on an empty FIFO, it is acknowledged 1 cycle after the push.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- **Reset.** Hold `Rst_n`=0 with `uart_rx` toggling → `uart_tx`=1, `CioAcq`=0, `stdin`=0x00 every cycle.
- **Output.** `Cout`=1 with `stdout`=0x41 → one `CioAcq` pulse. `uart_tx` shows 0,1,0,0,0,0,0,1,0,1 with each bit 4 cycles wide. A second `Cout` is not acknowledged until 40 cycles later and until `Cout` has dropped.
- **Input.** Send 0x35 on `uart_rx`, then raise `CinReq` → `CioAcq` is pulsed 1 cycle later with `stdin`=0x35. A held `CinReq` with an empty FIFO gets no further acknowledge.
- **Overrun.** Send 5 bytes 0x30..0x34 with `CinReq`=0 → `rx_overrun`=1. Four input grants then return 0x30..0x33.
- **Frame error and glitch.** A frame with stop bit 0 → `rx_frame_err` pulses once and the FIFO is unchanged. A 1-cycle low glitch on `uart_rx` → no byte is pushed.
- **Simultaneous requests.** `Cout` and `CinReq` rise in the same cycle with data queued → the output acknowledge comes first and the input acknowledge comes on a later cycle. `CioAcq` is never high for 2 consecutive cycles.
